// File: rtl/ahbl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_pkg
// Description : Shared AHB-Lite encodings, slave FSM states and lane helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Little-endian byte lanes touched by a transfer; unsupported sizes touch none.
  function automatic logic [3:0] lane_mask(input logic [1:0] addr, input logic [2:0] size);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr;
      HSIZE_HALF: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_mask = 4'b1111;
      default:    lane_mask = 4'b0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahbl_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_mem_array
// Description : DEPTH x DW flop memory, per-byte write enable, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_mem_array #(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [DW/8-1:0]   we,
  input  logic [IW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [IW-1:0]     raddr,
  output logic [DW-1:0]     rdata
);

  // One array per byte lane keeps every storage element single-driven.
  for (genvar gi = 0; gi < DW / 8; gi++) begin : g_lane
    logic [7:0] r_lane [DEPTH];

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        r_lane[waddr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = r_lane[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/ahbl_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_slave_mem
// Description : AHB-Lite memory slave with wait states and 2-cycle ERROR.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_slave_mem
  import ahbl_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RW          = 1,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [DW-1:0] hwdata,
  input  logic          error,
  output logic [DW-1:0] hrdata,
  output logic          hready,
  output logic [RW-1:0] hresp
);

  localparam int          c_IDXW  = $clog2(DEPTH);
  localparam int          c_NBYTE = DW / 8;
  localparam logic [AW:0] c_LIMIT = (AW+1)'(DEPTH * DW / 8);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic [c_IDXW+1:0]   r_addr;
  logic [2:0]          r_size;
  logic                r_write;

  logic                w_ready;
  logic                w_accept;
  logic                w_misalign;
  logic                w_oob;
  logic                w_err;
  logic                w_last;
  logic [c_NBYTE-1:0]  w_we;
  logic [DW-1:0]       w_rdata;
  logic                w_unused;

  assign w_unused = ^{hburst, hprot};

  assign w_last  = (r_state == ST_DATA) && (r_cnt == 4'd0);
  assign w_ready = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_last;

  assign w_accept = w_ready && hsel && (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);

  assign w_misalign = ((hsize == HSIZE_HALF) && haddr[0]) ||
                      ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
  assign w_oob      = ({1'b0, haddr} >= c_LIMIT);
  assign w_err      = error || w_oob || (hsize > HSIZE_WORD) || w_misalign;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_size  <= HSIZE_BYTE;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= haddr[c_IDXW+1:0];
        r_size  <= hsize;
        r_write <= hwrite;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_DATA: if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
      default: ;
    endcase
    // Every ready cycle is a decision point for the next transfer.
    if (w_ready) begin
      if (w_accept && w_err) begin
        w_state_nxt = ST_ERR1;
      end else if (w_accept) begin
        w_state_nxt = ST_DATA;
        w_cnt_nxt   = 4'(WAIT_STATES);
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  assign w_we = (w_last && r_write) ? lane_mask(r_addr[1:0], r_size) : '0;

  ahbl_mem_array #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .IW    (c_IDXW)
  ) u_mem (
    .clk   (hclk),
    .we    (w_we),
    .waddr (r_addr[c_IDXW+1:2]),
    .wdata (hwdata),
    .raddr (r_addr[c_IDXW+1:2]),
    .rdata (w_rdata)
  );

  assign hready = w_ready;
  assign hresp  = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? RW'(HRESP_ERROR) : RW'(HRESP_OKAY);
  assign hrdata = (w_last && !r_write) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahbl_slave_mem
// Description : Self-checking bench for ahbl_slave_mem (0 and 3 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_slave_mem;
  import ahbl_pkg::*;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          err;
    bit          exp_err;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          valid;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          err;
    bit          exp_err;
  } txn_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        error;
  logic [31:0] hrdata0, hrdata3;
  logic        hready0, hready3;
  logic [0:0]  hresp0, hresp3;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_m [1024];

  always #5 hclk = ~hclk;

  ahbl_slave_mem #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .error(error), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
  );

  ahbl_slave_mem #(.WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .error(error), .hrdata(hrdata3), .hready(hready3), .hresp(hresp3)
  );

  function automatic logic [31:0] rdy(bit s3);
    return s3 ? 32'(hready3) : 32'(hready0);
  endfunction
  function automatic logic [31:0] rsp(bit s3);
    return s3 ? 32'(hresp3) : 32'(hresp0);
  endfunction
  function automatic logic [31:0] rdat(bit s3);
    return s3 ? hrdata3 : hrdata0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata,
                               bit err, bit exp_err, logic [31:0] exp_rdata, string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.err = err; v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.name = name;
    return v;
  endfunction

  // Single non-overlapped transfer; entered and left on a falling edge.
  task automatic xfer(input bit s3, input vec_t v);
    int ws;
    ws     = s3 ? 3 : 0;
    hsel0  = !s3;
    hsel3  = s3;
    htrans = HTRANS_NONSEQ;
    hwrite = v.wr;
    haddr  = v.addr;
    hsize  = v.size;
    error  = v.err;
    @(negedge hclk);
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = HTRANS_IDLE;
    error  = 1'b0;
    hwdata = v.wdata;
    if (v.exp_err) begin
      chk($sformatf("%s err1_hready", v.name), rdy(s3), 32'd0);
      chk($sformatf("%s err1_hresp", v.name), rsp(s3), 32'd1);
      chk($sformatf("%s err1_hrdata", v.name), rdat(s3), 32'd0);
      @(negedge hclk);
      chk($sformatf("%s err2_hready", v.name), rdy(s3), 32'd1);
      chk($sformatf("%s err2_hresp", v.name), rsp(s3), 32'd1);
      chk($sformatf("%s err2_hrdata", v.name), rdat(s3), 32'd0);
    end else begin
      for (int i = 0; i < ws; i++) begin
        chk($sformatf("%s wait%0d_hready", v.name, i), rdy(s3), 32'd0);
        chk($sformatf("%s wait%0d_hrdata", v.name, i), rdat(s3), 32'd0);
        @(negedge hclk);
      end
      chk($sformatf("%s done_hready", v.name), rdy(s3), 32'd1);
      chk($sformatf("%s done_hresp", v.name), rsp(s3), 32'd0);
      if (!v.wr) chk($sformatf("%s rdata", v.name), rdat(s3), v.exp_rdata);
    end
    @(negedge hclk);
  endtask

  function automatic logic [31:0] model_read(logic [31:0] addr);
    int a;
    a = int'(addr) & ~3;
    return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
  endfunction

  function automatic void model_write(logic [31:0] addr, logic [2:0] size, logic [31:0] wdata);
    int n;
    int a;
    n = 1 << size;
    for (int i = 0; i < n; i++) begin
      a = int'(addr) + i;
      mem_m[a] = wdata[8*(a % 4) +: 8];
    end
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   n;
    t.wr    = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    t.err   = ($urandom_range(0, 11) == 0);
    t.size  = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    n       = 1 << ((t.size > 3'd2) ? 2 : int'(t.size));
    case ($urandom_range(0, 15))
      0:       t.addr = 32'(1024 + $urandom_range(0, 4095));
      1, 2:    t.addr = 32'($urandom_range(0, 1023));
      default: t.addr = 32'($urandom_range(0, 1023) & ~(n - 1));
    endcase
    case ($urandom_range(0, 9))
      0:       begin t.sel = 1'b0; t.trans = HTRANS_NONSEQ; end
      1:       begin t.sel = 1'b1; t.trans = 2'($urandom_range(0, 1)); end
      default: begin t.sel = 1'b1; t.trans = $urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ; end
    endcase
    t.valid   = t.sel && t.trans[1];
    t.exp_err = t.err || (t.addr >= 32'd1024) || (t.size > 3'd2) ||
                ((t.size == 3'd1) && (t.addr % 2 != 0)) ||
                ((t.size == 3'd2) && (t.addr % 4 != 0));
    return t;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    txn_t pend, nx;
    logic [31:0] exp;

    hresetn = 1'b0;
    hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_WORD; hburst = 3'd0; hprot = 4'd0; hwdata = '0; error = 1'b0;

    repeat (2) @(negedge hclk);
    chk("reset hready0", 32'(hready0), 32'd1);
    chk("reset hresp0", 32'(hresp0), 32'd0);
    chk("reset hrdata0", hrdata0, 32'd0);
    chk("reset hready3", 32'(hready3), 32'd1);
    hresetn = 1'b1;
    @(negedge hclk);

    tbl.push_back(mkv(1, 32'h10,  HSIZE_WORD, 32'hDEADBEEF, 0, 0, 32'h0,        "w_word10"));
    tbl.push_back(mkv(0, 32'h10,  HSIZE_WORD, 32'h0,        0, 0, 32'hDEADBEEF, "r_word10"));
    tbl.push_back(mkv(1, 32'h10,  HSIZE_WORD, 32'h11223344, 0, 0, 32'h0,        "w_base10"));
    tbl.push_back(mkv(1, 32'h13,  HSIZE_BYTE, 32'hAA000000, 0, 0, 32'h0,        "w_byte13"));
    tbl.push_back(mkv(0, 32'h10,  HSIZE_WORD, 32'h0,        0, 0, 32'hAA223344, "r_after_byte"));
    tbl.push_back(mkv(0, 32'h11,  HSIZE_BYTE, 32'h0,        0, 0, 32'hAA223344, "r_byte11"));
    tbl.push_back(mkv(1, 32'h30,  HSIZE_WORD, 32'h00000055, 0, 0, 32'h0,        "w_word30"));
    tbl.push_back(mkv(1, 32'h30,  HSIZE_WORD, 32'h000000FF, 1, 1, 32'h0,        "w_err30"));
    tbl.push_back(mkv(0, 32'h30,  HSIZE_WORD, 32'h0,        0, 0, 32'h00000055, "r_word30"));
    tbl.push_back(mkv(0, 32'h402, HSIZE_WORD, 32'h0,        0, 1, 32'h0,        "r_mis402"));
    tbl.push_back(mkv(1, 32'h400, HSIZE_WORD, 32'h12345678, 0, 1, 32'h0,        "w_oob400"));
    tbl.push_back(mkv(0, 32'h11,  HSIZE_HALF, 32'h0,        0, 1, 32'h0,        "r_mis_half"));
    tbl.push_back(mkv(0, 32'h10,  3'd3,       32'h0,        0, 1, 32'h0,        "r_bad_size"));
    tbl.push_back(mkv(1, 32'h12,  HSIZE_HALF, 32'hBEEF0000, 0, 0, 32'h0,        "w_half12"));
    tbl.push_back(mkv(0, 32'h10,  HSIZE_WORD, 32'h0,        0, 0, 32'hBEEF3344, "r_after_half"));
    tbl.push_back(mkv(1, 32'h3FC, HSIZE_WORD, 32'h01020304, 0, 0, 32'h0,        "w_last_word"));
    tbl.push_back(mkv(1, 32'h3FF, HSIZE_BYTE, 32'h7E000000, 0, 0, 32'h0,        "w_last_byte"));
    tbl.push_back(mkv(1, 32'h3FD, HSIZE_WORD, 32'hFFFFFFFF, 0, 1, 32'h0,        "w_mis3fd"));
    tbl.push_back(mkv(0, 32'h3FC, HSIZE_WORD, 32'h0,        0, 0, 32'h7E020304, "r_last_word"));
    foreach (tbl[i]) xfer(1'b0, tbl[i]);

    // Wait-state instance: write then read, ERROR timing, reset mid-write.
    xfer(1'b1, mkv(1, 32'h20, HSIZE_WORD, 32'hCAFEF00D, 0, 0, 32'h0,        "ws3_w20"));
    xfer(1'b1, mkv(0, 32'h20, HSIZE_WORD, 32'h0,        0, 0, 32'hCAFEF00D, "ws3_r20"));
    xfer(1'b1, mkv(0, 32'h402, HSIZE_WORD, 32'h0,       0, 1, 32'h0,        "ws3_mis402"));
    xfer(1'b1, mkv(1, 32'h24, HSIZE_WORD, 32'h12345678, 0, 0, 32'h0,        "ws3_w24"));

    hsel3 = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h24; hsize = HSIZE_WORD;
    @(negedge hclk);
    hsel3 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF;
    chk("rst_mid wait_hready", 32'(hready3), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    chk("rst_mid hready", 32'(hready3), 32'd1);
    chk("rst_mid hresp", 32'(hresp3), 32'd0);
    chk("rst_mid hrdata", hrdata3, 32'd0);
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    xfer(1'b1, mkv(0, 32'h24, HSIZE_WORD, 32'h0, 0, 0, 32'h12345678, "rst_mid r24"));

    // Fill the whole memory so the model knows every byte.
    for (int w = 0; w < 256; w++) begin
      v = mkv(1, 32'(w * 4), HSIZE_WORD, $urandom, 0, 0, 32'h0, $sformatf("init%0d", w));
      xfer(1'b0, v);
      model_write(v.addr, v.size, v.wdata);
    end

    // Pipelined random traffic at full rate against the byte-array model.
    pend = '{default: '0};
    for (int k = 0; k <= 600; k++) begin
      if (k < 600) nx = rand_txn();
      else nx = '{default: '0};
      hsel0  = nx.sel;
      htrans = nx.trans;
      hwrite = nx.wr;
      haddr  = nx.addr;
      hsize  = nx.size;
      error  = nx.err;
      hwdata = pend.wdata;
      if (pend.valid && pend.exp_err) begin
        chk($sformatf("rnd%0d err1_hready", k), 32'(hready0), 32'd0);
        chk($sformatf("rnd%0d err1_hresp", k), 32'(hresp0), 32'd1);
        @(negedge hclk);
        chk($sformatf("rnd%0d err2_hready", k), 32'(hready0), 32'd1);
        chk($sformatf("rnd%0d err2_hresp", k), 32'(hresp0), 32'd1);
        chk($sformatf("rnd%0d err2_hrdata", k), hrdata0, 32'd0);
      end else if (pend.valid) begin
        chk($sformatf("rnd%0d hready", k), 32'(hready0), 32'd1);
        chk($sformatf("rnd%0d hresp", k), 32'(hresp0), 32'd0);
        if (pend.wr) begin
          model_write(pend.addr, pend.size, pend.wdata);
        end else begin
          exp = model_read(pend.addr);
          chk($sformatf("rnd%0d rdata@%0h", k, pend.addr), hrdata0, exp);
        end
      end else begin
        chk($sformatf("rnd%0d idle_ready", k), 32'(hready0), 32'd1);
        chk($sformatf("rnd%0d idle_rdata", k), hrdata0 | 32'(hresp0), 32'd0);
      end
      @(negedge hclk);
      pend = nx;
    end
    hsel0 = 1'b0; htrans = HTRANS_IDLE; error = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahbl_slave_mem.md
# ahbl_slave_mem

AHB-Lite slave with an internal word-addressed memory: the design under test that sits directly behind the AHB-Lite bus interface and consumes the master-side signals the driver places on it. Supports byte/halfword/word transfers, programmable wait-state insertion, and the two-cycle ERROR response. Triggers for that response: the `error` control input, out-of-range addresses, and illegal size/alignment. Single-slave system: `hready` is both this block's HREADYOUT and the bus HREADY fed back to it.

## Interface
- AW, 32, address width
- DW, 32, data width; only 32 is supported
- RW, 1, hresp width
- DEPTH, 256, memory depth in DW-bit words
- WAIT_STATES, 0, hready-low cycles inserted per OKAY data phase (0..15)

- hclk  in  1  bus clock, all state on rising edge
- hresetn  in  1  reset, asynchronous, active-low
- hsel  in  1  slave select
- haddr  in  AW  byte address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1=write
- hsize  in  3  0=byte, 1=half, 2=word
- hburst  in  3  ignored; bursts are handled as independent beats
- hprot  in  4  ignored
- hwdata  in  DW  write data, valid in data phase
- error  in  1  sampled with the address phase; forces ERROR response
- hrdata  out  DW  read data
- hready  out  1  transfer done
- hresp  out  RW  0=OKAY, 1=ERROR

## Operation
- Address phase is accepted on a rising edge where hready=1, hsel=1 and htrans[1]=1. Latch: haddr, hwrite, hsize, error.
- hsel=0, or IDLE/BUSY at the accepting edge: no data phase, zero-wait OKAY.
- Error conditions, evaluated at acceptance:
  - error=1
  - haddr >= DEPTH*DW/8
  - hsize > 2
  - misaligned: half with haddr[0]=1; word with haddr[1:0]!=0
- FSM states:
  - IDLE: hready=1, hresp=0.
  - DATA: wait counter loads WAIT_STATES. hready=0 while counter>0, decrement each cycle. hready=1, hresp=0 when counter=0.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- Transitions, taken on an accepting edge from IDLE, from DATA with counter=0, or from ERR2:
  - legal transfer -> DATA
  - error condition -> ERR1
  - otherwise -> IDLE
- ERR1 -> ERR2 unconditionally.
- Write: byte lanes are little-endian and selected by haddr[1:0]/hsize. Memory is updated on the edge ending the data phase (hready=1, DATA). Errored transfers never write.
- Read: hrdata carries the full addressed word in the DATA cycle with hready=1. hrdata=0 in all other cycles, including ERR1/ERR2.
- Memory is a flop array, read asynchronously from the latched address. A write followed immediately by a read of the same word returns the new data.

## Timing
- Reset values: hready=1, hresp=0, hrdata=0, state IDLE, counter 0. Memory contents are not reset.
- OKAY latency: address phase edge + (WAIT_STATES+1) cycles. With WAIT_STATES=0, data completes in the cycle after the address phase.
- ERROR response is always exactly 2 cycles, regardless of WAIT_STATES.
- Pipelining: the next address phase overlaps the final data cycle (hready=1). Back-to-back transfers run at full rate when WAIT_STATES=0.
- Address-phase inputs are ignored while hready=0.
- Reset asserted mid-transfer: transfer aborts, no memory write, outputs return to reset values asynchronously.

## Structure
- Package ahbl_pkg holds:
  - htrans codes
  - hsize codes
  - hresp codes
  - state enum {IDLE, DATA, ERR1, ERR2}
  - function computing the byte-lane mask from addr[1:0]/hsize
- Sub-module ahbl_mem_array: DEPTH x DW flop array, per-byte write enable, async read port.

## Test plan
- Write word 0xDEADBEEF to 0x10, then read 0x10, WAIT_STATES=0 -> write completes with hready=1 the next cycle; read returns 0xDEADBEEF, hresp=0.
- Byte write 0xAA to 0x13 over word 0x11223344 -> read of 0x10 returns 0xAA223344.
- WAIT_STATES=3, read 0x20 -> hready low 3 cycles, high on the 4th, data valid only then.
- Word read at 0x402 (misaligned) and word write to 0x400 (out of range, DEPTH=256) -> each gets hready 0 then 1 with hresp=1 for 2 cycles, hrdata=0, memory unchanged.
- Write with error=1 to 0x30 holding 0x55 -> 2-cycle ERROR; subsequent read of 0x30 returns 0x55.
- Assert hresetn low during the wait state of a write -> hready=1, hresp=0 immediately; target word unchanged after reset release.
